sc_inst_encoder: RTL
====================

Name: sc_inst_encoder

Overview:
- Instruction encoder and program loader for the single-cycle MIPS CPU with IO. It is the encode-direction counterpart of the control-unit instruction decoder.
- Accepts a symbolic instruction (mnemonic index plus fields) over a valid/ready handshake, packs it into a 32-bit MIPS word, and emits it with a sequential word address for writing into instruction memory.
- Covers the same 20-instruction subset the CPU executes.
- Feeds the IMEM write port during program-load mode.

Parameters:
- ADDR_W, 6, width of emitted word address.
- DEPTH, 64, number of IMEM words; full asserts after word DEPTH-1 is emitted; DEPTH <= 2^ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- restart  in  1  sync pulse: clear pointer, full, pending output.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  encoder can accept this cycle.
- mnem  in  5  mnemonic index (see Behaviour).
- rs  in  5  source register field.
- rt  in  5  target register field.
- rd  in  5  destination register field.
- imm16  in  16  immediate; shamt taken from imm16[4:0] for shifts.
- addr26  in  26  jump target field for j/jal.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer (IMEM writer) takes word.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address for out_word.
- count  out  ADDR_W+1  words emitted since reset/restart.
- full  out  1  DEPTH words emitted; input blocked.
- err  out  1  one-cycle pulse on an accepted illegal mnemonic.

Behaviour:
- Mnemonic map: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 addi, 10 andi, 11 ori, 12 xori, 13 lw, 14 sw, 15 beq, 16 bne, 17 lui, 18 j, 19 jal. Indices 20-31 are illegal.
- R-type (0-8): op=000000.
  - add/sub/and/or/xor: {rs,rt,rd,5'b0,func}.
  - Shifts (sll/srl/sra): rs field=0, {rt,rd,imm16[4:0],func}.
  - jr: {rs,15'b0,001000}.
  - func codes: 100000, 100010, 100100, 100101, 100110, 000000, 000010, 000011.
- I-type: {op,rs,rt,imm16}.
  - op codes: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111.
  - lui forces rs field=0.
- J-type: {op,addr26}; j 000010, jal 000011.
- Handshake: in_ready = resetn & ~restart & ~full & (~out_valid | out_ready). Accept occurs when in_valid & in_ready.
- Output stage is a single register; latency is 1 cycle from accept to out_valid.
- out_word/out_addr are held stable while out_valid & ~out_ready.
- Legal accept: out_word <= encoding, out_addr <= wr_ptr, out_valid <= 1, wr_ptr <= wr_ptr+1 (mod 2^ADDR_W), count <= count+1. full <= 1 when the emitted address == DEPTH-1.
- Same-cycle accept and output handoff (out_valid & out_ready & accept): out_valid stays 1 with the new word; no bubble.
- out_ready with no new accept: out_valid <= 0.
- Illegal accept: consumed, no output, pointer and count unchanged, err=1 for exactly the next cycle.
- full: sticky; in_ready=0. A pending last word still drains normally.
- restart: wr_ptr, count, full, out_valid <= 0; any pending word is dropped. Restart wins over a simultaneous in_valid (in_ready=0 that cycle).
- Reset (resetn=0 at edge): out_valid=0, out_word=0, out_addr=0, count=0, full=0, err=0, wr_ptr=0. Reset mid-transfer discards the pending word.
- Out-of-range field bits: never present (all fields are fixed width); imm16[15:5] ignored for shifts.

Optional Feature:
- Macro: SC_ENC_FIELD_CHECK_EN.
- Defined: the following count as illegal (err pulse, no output):
  - shift with imm16[15:5] != 0;
  - R-type arithmetic/shift with rd == 0;
  - I-type ALU/lw/lui with rt == 0.
- Undefined: no field checks; bits are truncated or encoded as given.

Test Plan:
- mnem=0, rs=1, rt=2, rd=3 -> next cycle out_valid=1, out_word=0x00221820, out_addr=0, count=1.
- mnem=13, rs=5, rt=4, imm16=8 -> out_word=0x8CA40008, out_addr increments.
- mnem=5, rt=3, rd=2, imm16=4 -> 0x00031100. mnem=19, addr26=0x10 -> 0x0C000010.
- out_ready=0, two back-to-back inputs -> first held stable, in_ready=0, second accepted the cycle out_ready rises; no word lost or duplicated.
- mnem=25 -> err pulse 1 cycle, out_valid stays 0, count unchanged. With SC_ENC_FIELD_CHECK_EN, sll with imm16=0x0020 -> err.
- DEPTH=4: four legal words -> full=1 after addr 3, in_ready=0. restart -> full=0, count=0, next word at out_addr=0.

Source files
------------

// File: rtl/sc_inst_encoder.sv
// Symbolic-to-binary MIPS instruction encoder feeding the IMEM write port during program load.
// Optional field legality checks are enabled by defining SC_ENC_FIELD_CHECK_EN.
module sc_inst_encoder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm16,
    input  logic [25:0]       addr26,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    function automatic logic [31:0] encode(
        input logic [4:0]  m,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [25:0] f_addr
    );
        logic [31:0] w;
        case (m)
            5'd0:  w = {OP_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_ADD};
            5'd1:  w = {OP_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_SUB};
            5'd2:  w = {OP_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_AND};
            5'd3:  w = {OP_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_OR};
            5'd4:  w = {OP_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_XOR};
            5'd5:  w = {OP_RTYPE, 5'd0, f_rt, f_rd, f_imm[4:0], FN_SLL};
            5'd6:  w = {OP_RTYPE, 5'd0, f_rt, f_rd, f_imm[4:0], FN_SRL};
            5'd7:  w = {OP_RTYPE, 5'd0, f_rt, f_rd, f_imm[4:0], FN_SRA};
            5'd8:  w = {OP_RTYPE, f_rs, 15'd0, FN_JR};
            5'd9:  w = {OP_ADDI, f_rs, f_rt, f_imm};
            5'd10: w = {OP_ANDI, f_rs, f_rt, f_imm};
            5'd11: w = {OP_ORI,  f_rs, f_rt, f_imm};
            5'd12: w = {OP_XORI, f_rs, f_rt, f_imm};
            5'd13: w = {OP_LW,   f_rs, f_rt, f_imm};
            5'd14: w = {OP_SW,   f_rs, f_rt, f_imm};
            5'd15: w = {OP_BEQ,  f_rs, f_rt, f_imm};
            5'd16: w = {OP_BNE,  f_rs, f_rt, f_imm};
            5'd17: w = {OP_LUI,  5'd0, f_rt, f_imm};
            5'd18: w = {OP_J,   f_addr};
            5'd19: w = {OP_JAL, f_addr};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

`ifdef SC_ENC_FIELD_CHECK_EN
    // Rejects unknown mnemonics plus field combinations that would encode a useless or truncated instruction.
    function automatic logic is_illegal(
        input logic [4:0]  m,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm
    );
        logic bad;
        bad = (m > 5'd19);
        if ((m >= 5'd5) && (m <= 5'd7) && (f_imm[15:5] != 11'd0)) bad = 1'b1;
        if ((m <= 5'd7) && (f_rd == 5'd0)) bad = 1'b1;
        if ((((m >= 5'd9) && (m <= 5'd13)) || (m == 5'd17)) && (f_rt == 5'd0)) bad = 1'b1;
        return bad;
    endfunction
`else
    function automatic logic is_illegal(input logic [4:0] m);
        return (m > 5'd19);
    endfunction
`endif

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [ADDR_W:0]   count_r;
    logic [31:0]       out_word_r;
    logic              out_valid_r;
    logic              full_r;
    logic              err_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              illegal_s;
    logic [31:0]       word_s;

    // Handshake and encoding of the presented instruction.
    always_comb begin
        in_ready_s = resetn & ~restart & ~full_r & (~out_valid_r | out_ready);
        accept_s   = in_valid & in_ready_s;
        word_s     = encode(mnem, rs, rt, rd, imm16, addr26);
`ifdef SC_ENC_FIELD_CHECK_EN
        illegal_s  = is_illegal(mnem, rt, rd, imm16);
`else
        illegal_s  = is_illegal(mnem);
`endif
    end

    // Output register, write pointer, word count and status flags.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_r    <= '0;
            out_addr_r  <= '0;
            count_r     <= '0;
            out_word_r  <= 32'd0;
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
            err_r       <= 1'b0;
        end else if (restart) begin
            wr_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            err_r <= accept_s & illegal_s;
            if (accept_s && !illegal_s) begin
                // A new word replaces a word being handed off in the same cycle, so no bubble.
                out_word_r  <= word_s;
                out_addr_r  <= wr_ptr_r;
                out_valid_r <= 1'b1;
                wr_ptr_r    <= wr_ptr_r + ADDR_W'(1);
                count_r     <= count_r + (ADDR_W + 1)'(1);
                if (wr_ptr_r == LAST_ADDR) begin
                    full_r <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
    assign out_addr  = out_addr_r;
    assign count     = count_r;
    assign full      = full_r;
    assign err       = err_r;

endmodule
